// File: rtl/icache_pkg.sv
// icache_pkg
// Shared definitions for the instruction cache: FSM state encoding, the NOP
// returned when no instruction is available, and address-field width helpers.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int offset_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int num_sets, input int block_words);
    return 32 - 2 - $clog2(num_sets) - $clog2(block_words);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// icache_line_array
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   CLK, RESET          clock, async active-low reset (clears valid bits only)
//   rd_index            combinational read port -> rd_valid, rd_tag, rd_block
//   wr_en, wr_index,    synchronous line write; sets the line's valid bit
//   wr_tag, wr_block
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 25
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [index_w(NUM_SETS)-1:0]         rd_index,
  output logic                                 rd_valid,
  output logic [TAG_W-1:0]                     rd_tag,
  output logic [BLOCK_WORDS-1:0][31:0]         rd_block,
  input  logic                                 wr_en,
  input  logic [index_w(NUM_SETS)-1:0]         wr_index,
  input  logic [TAG_W-1:0]                     wr_tag,
  input  logic [BLOCK_WORDS-1:0][31:0]         wr_block
);

  logic [NUM_SETS-1:0]          valid;
  logic [TAG_W-1:0]             tags [NUM_SETS];
  logic [BLOCK_WORDS-1:0][31:0] data [NUM_SETS];

  // Only valid bits need reset; tag/data contents are qualified by valid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_block;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_block = data[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// instruction_cache
// Direct-mapped read-only instruction cache. Hits return in the request
// cycle; a miss stalls the pipeline, reads the whole block from memory and
// writes it into the line array, after which the request completes as a hit.
// Ports:
//   CLK, RESET              clock, async active-low reset
//   ADDRESS, insReadEn      fetch byte address and request
//   INSTRUCTION             fetched word (NOP when nothing is served)
//   INS_CACHE_BUSY_WAIT     stall to the CPU
//   MEM_READ, MEM_ADDRESS   block read request / block address to memory
//   MEM_READDATA            returned block, word 0 in bits [31:0]
//   MEM_BUSYWAIT            memory busy; data valid the cycle it is low
//   HIT_COUNT, MISS_COUNT   saturating counters, only with ICACHE_PERF_CNT_EN
//
// state  | meaning
// IDLE   | lookup; hit served combinationally, miss latches block address
// FETCH  | MEM_READ high until memory drops busy, then block captured
// UPDATE | captured block, tag and valid written to the latched line
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [31:0]                           ADDRESS,
  input  logic                                  insReadEn,
  output logic [31:0]                           INSTRUCTION,
  output logic                                  INS_CACHE_BUSY_WAIT,
  output logic                                  MEM_READ,
  output logic [32-offset_w(BLOCK_WORDS)-3:0]   MEM_ADDRESS,
  input  logic [32*BLOCK_WORDS-1:0]             MEM_READDATA,
  input  logic                                  MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                           HIT_COUNT,
  output logic [31:0]                           MISS_COUNT
`endif
);

  localparam int OFF_W = offset_w(BLOCK_WORDS);
  localparam int IDX_W = index_w(NUM_SETS);
  localparam int TAG_W = tag_w(NUM_SETS, BLOCK_WORDS);
  localparam int BLK_W = 32 - OFF_W - 2;

  state_t state, state_nxt;

  logic [BLK_W-1:0]             req_blk;
  logic [OFF_W-1:0]             req_off;
  logic [IDX_W-1:0]             req_idx;
  logic [TAG_W-1:0]             req_tag;
  logic                         unused_byte_sel;

  logic [BLK_W-1:0]             miss_blk;
  logic [BLOCK_WORDS-1:0][31:0] fill_block;

  logic                         rd_valid;
  logic [TAG_W-1:0]             rd_tag;
  logic [BLOCK_WORDS-1:0][31:0] rd_block;
  logic                         hit;
  logic                         miss_start;
  logic                         wr_en;

  assign req_blk         = ADDRESS[31:OFF_W+2];
  assign req_off         = ADDRESS[OFF_W+1:2];
  assign req_idx         = req_blk[IDX_W-1:0];
  assign req_tag         = req_blk[BLK_W-1:IDX_W];
  assign unused_byte_sel = ^ADDRESS[1:0];

  icache_line_array #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS),
    .TAG_W       (TAG_W)
  ) u_lines (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_block (rd_block),
    .wr_en    (wr_en),
    .wr_index (miss_blk[IDX_W-1:0]),
    .wr_tag   (miss_blk[BLK_W-1:IDX_W]),
    .wr_block (fill_block)
  );

  assign hit        = insReadEn & rd_valid & (rd_tag == req_tag);
  assign miss_start = (state == IDLE) & insReadEn & ~hit;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      miss_blk   <= '0;
      fill_block <= '0;
    end else begin
      state <= state_nxt;
      if (miss_start) miss_blk <= req_blk;
      if (state == FETCH && !MEM_BUSYWAIT) fill_block <= MEM_READDATA;
    end
  end

  always_comb begin
    state_nxt           = state;
    INSTRUCTION         = NOP_INSTR;
    INS_CACHE_BUSY_WAIT = 1'b0;
    MEM_READ            = 1'b0;
    wr_en               = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) INSTRUCTION = rd_block[req_off];
        INS_CACHE_BUSY_WAIT = miss_start;
        if (miss_start) state_nxt = FETCH;
      end
      FETCH: begin
        INS_CACHE_BUSY_WAIT = 1'b1;
        MEM_READ            = 1'b1;
        if (!MEM_BUSYWAIT) state_nxt = UPDATE;
      end
      UPDATE: begin
        INS_CACHE_BUSY_WAIT = 1'b1;
        wr_en               = 1'b1;
        state_nxt           = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address register is cleared by reset, so MEM_ADDRESS reads 0 out of reset.
  assign MEM_ADDRESS = miss_blk;

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (state == IDLE && hit && HIT_COUNT != 32'hFFFF_FFFF)
        HIT_COUNT <= HIT_COUNT + 32'd1;
      if (miss_start && MISS_COUNT != 32'hFFFF_FFFF)
        MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule
